// File: rtl/key_storage_ctrl.sv
// Sequencing controller for the round-key circular LIFO: loads DEPTH keys in generation
// order, then serves them in reverse order by rotating the LIFO, replaying indefinitely.
module key_storage_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [WIDTH-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [WIDTH-1:0] out_key,
  output logic [CW-1:0]    out_idx,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             loaded,
  output logic [WIDTH-1:0] lifo_din,
  input  logic [WIDTH-1:0] lifo_dout,
  output logic             lifo_en,
  output logic             lifo_push
);

  typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

  localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          key_hs, out_hs;

  assign lifo_din = key_in;
  assign out_key  = lifo_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (load_start) begin
      // A new load always wins, abandoning whatever was in progress.
      state_d  = StLoad;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      case (state_q)
        StLoad: begin
          if (key_hs) begin
            if (wr_cnt_q == LastIdx) begin
              state_d  = StReady;
              wr_cnt_d = '0;
              rd_cnt_d = '0;
            end else begin
              wr_cnt_d = wr_cnt_q + CW'(1);
            end
          end
        end
        StReady: begin
          if (out_hs) begin
            rd_cnt_d = (rd_cnt_q == LastIdx) ? '0 : rd_cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    key_ready = (state_q == StLoad) && !load_start;
    out_valid = (state_q == StReady) && !load_start;
    key_hs    = key_valid && key_ready;
    out_hs    = out_valid && out_ready;
    lifo_en   = key_hs || out_hs;
    lifo_push = (state_q == StLoad);
    loaded    = (state_q == StReady);
    out_idx   = LastIdx - rd_cnt_q;
    out_last  = out_valid && (rd_cnt_q == LastIdx);
  end

endmodule
